// File: rtl/core_pmp_checker.sv
// core_pmp_checker: multi-port pipelined PMP checker that also holds the
// architectural pmpcfg/pmpaddr state for the CSR file.
//
// Ports:
//   g_clk, g_reset                  clock, async active-high reset
//   csr_en/csr_wr/csr_addr/csr_wdata CSR access (full writes only)
//   csr_rdata, csr_error             combinational read data / not-a-PMP-CSR flag
//   req_valid/req_ready/req_addr/req_prv/req_acc  per-port request channel
//   rsp_valid/rsp_ready/rsp_trap     per-port registered response (1 cycle)
//
// Optional build macro: CORE_PMP_FAULT_LOG_EN adds a sticky first-trap capture
// register at CSR 0x7C0 {valid, port[2:0], acc[2:0], byte address}.

// One check channel: region match, priority select, decision and response reg.
module core_pmp_port #(
  parameter int AW  = 56,
  parameter int NR  = 16,
  parameter int NRA = 16
) (
  input  logic                     g_clk,
  input  logic                     g_reset,
  input  logic [NRA-1:0][7:0]      i_cfg,
  input  logic [NRA-1:0][AW-3:0]   i_addr,
  input  logic                     i_req_valid,
  output logic                     o_req_ready,
  input  logic [AW-1:0]            i_req_addr,
  input  logic [1:0]               i_req_prv,
  input  logic [2:0]               i_req_acc,
  output logic                     o_rsp_valid,
  input  logic                     i_rsp_ready,
  output logic                     o_rsp_trap,
  output logic                     o_trap_acc
);
  localparam logic [AW-3:0] ONE = 1;

  logic [AW-3:0]  w_a;
  logic [NRA-1:0] w_hit;
  logic           w_fnd, w_lk, w_m, w_perm, w_acc;
  logic [2:0]     w_rwx;
  logic           r_vld, r_trap;

  assign w_a = i_req_addr[AW-1:2];

  for (genvar i = 0; i < NRA; i++) begin : g_rgn
    logic [AW-3:0] w_base, w_nmask;
    logic          w_h;
    if (i == 0) begin : g_b0
      assign w_base = '0;
    end else begin : g_bn
      assign w_base = i_addr[i-1];
    end
    // Bits [k:0] set for k trailing ones; all-ones pmpaddr gives a full mask.
    assign w_nmask = i_addr[i] ^ (i_addr[i] + ONE);
    always_comb begin
      w_h = 1'b0;
      if (i < NR) begin
        case (i_cfg[i][4:3])
          2'b01:   w_h = (w_a >= w_base) && (w_a < i_addr[i]);
          2'b10:   w_h = (w_a == i_addr[i]);
          2'b11:   w_h = ((w_a ^ i_addr[i]) & ~w_nmask) == '0;
          default: w_h = 1'b0;
        endcase
      end
    end
    assign w_hit[i] = w_h;
  end

  // Scan high to low so the lowest-numbered hit is the one left standing.
  always_comb begin
    w_fnd = 1'b0;
    w_rwx = 3'b000;
    w_lk  = 1'b0;
    for (int i = NRA - 1; i >= 0; i--) begin
      if (w_hit[i]) begin
        w_fnd = 1'b1;
        w_rwx = i_cfg[i][2:0];
        w_lk  = i_cfg[i][7];
      end
    end
    w_m = (i_req_prv == 2'b11);
    if (w_fnd) w_perm = (w_m && !w_lk) || (|(i_req_acc & w_rwx));
    else       w_perm = w_m || (NR == 0);
  end

  assign o_req_ready = !r_vld || i_rsp_ready;
  assign w_acc       = i_req_valid && o_req_ready;
  assign o_trap_acc  = w_acc && !w_perm;
  assign o_rsp_valid = r_vld;
  assign o_rsp_trap  = r_trap;

  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      r_vld  <= 1'b0;
      r_trap <= 1'b0;
    end else if (w_acc) begin
      r_vld  <= 1'b1;
      r_trap <= !w_perm;
    end else if (i_rsp_ready) begin
      r_vld  <= 1'b0;
    end
  end
endmodule

module core_pmp_checker #(
  parameter int ADDR_WIDTH  = 56,
  parameter int NUM_REGIONS = 16,
  parameter int NUM_PORTS   = 2,
  parameter int EN_TOR      = 1
) (
  input  logic                          g_clk,
  input  logic                          g_reset,
  input  logic                          csr_en,
  input  logic                          csr_wr,
  input  logic [11:0]                   csr_addr,
  input  logic [63:0]                   csr_wdata,
  output logic [63:0]                   csr_rdata,
  output logic                          csr_error,
  input  logic [NUM_PORTS-1:0]          req_valid,
  output logic [NUM_PORTS-1:0]          req_ready,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_PORTS*2-1:0]        req_prv,
  input  logic [NUM_PORTS*3-1:0]        req_acc,
  output logic [NUM_PORTS-1:0]          rsp_valid,
  input  logic [NUM_PORTS-1:0]          rsp_ready,
  output logic [NUM_PORTS-1:0]          rsp_trap
);
  localparam int AW  = ADDR_WIDTH;
  localparam int NRA = (NUM_REGIONS > 0) ? NUM_REGIONS : 1;

  logic [NRA-1:0][7:0]    r_cfg;
  logic [NRA-1:0][AW-3:0] r_addr;
  logic [NRA-1:0]         w_cfg_we, w_addr_we, w_nlk;
  logic [NUM_PORTS-1:0]   w_tacc;
  logic                   w_wr, w_is_cfg, w_is_paddr, w_is_log;
  logic [2:0]             w_cfg_m;
  logic [5:0]             w_pidx;

  // Stored form: bits [6:5] zero, W only with R, TOR folded to OFF if absent.
  function automatic logic [7:0] f_warl(input logic [7:0] v);
    logic [1:0] a;
    a = v[4:3];
    if (EN_TOR == 0 && a == 2'b01) a = 2'b00;
    return {v[7], 2'b00, a, v[2], v[1] & v[0], v[0]};
  endfunction

  assign w_wr       = csr_en && csr_wr;
  assign w_is_cfg   = (csr_addr[11:4] == 8'h3A) && !csr_addr[0];
  assign w_is_paddr = (csr_addr >= 12'h3B0) && (csr_addr <= 12'h3EF);
  assign w_cfg_m    = csr_addr[3:1];
  assign w_pidx     = 6'(csr_addr - 12'h3B0);
`ifdef CORE_PMP_FAULT_LOG_EN
  assign w_is_log   = (csr_addr == 12'h7C0);
`else
  assign w_is_log   = 1'b0;
`endif
  assign csr_error  = !(w_is_cfg || w_is_paddr || w_is_log);

  for (genvar i = 0; i < NRA; i++) begin : g_we
    // A locked TOR entry also freezes the pmpaddr below it (its base).
    if (i + 1 < NUM_REGIONS) begin : g_nl
      assign w_nlk[i] = r_cfg[i+1][7] && (r_cfg[i+1][4:3] == 2'b01);
    end else begin : g_nn
      assign w_nlk[i] = 1'b0;
    end
    assign w_cfg_we[i]  = w_wr && w_is_cfg && (w_cfg_m == 3'(i / 8)) &&
                          !r_cfg[i][7] && (i < NUM_REGIONS);
    assign w_addr_we[i] = w_wr && w_is_paddr && (w_pidx == 6'(i)) &&
                          !r_cfg[i][7] && !w_nlk[i] && (i < NUM_REGIONS);
  end

  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      r_cfg  <= '0;
      r_addr <= '0;
    end else begin
      for (int i = 0; i < NRA; i++) begin
        if (w_cfg_we[i])  r_cfg[i]  <= f_warl(csr_wdata[(i % 8) * 8 +: 8]);
        if (w_addr_we[i]) r_addr[i] <= csr_wdata[AW-3:0];
      end
    end
  end

`ifdef CORE_PMP_FAULT_LOG_EN
  logic          r_log_vld, w_lg_hit;
  logic [2:0]    r_log_port, r_log_acc, w_lg_port, w_lg_acc;
  logic [AW-1:0] r_log_addr, w_lg_addr;

  always_comb begin
    w_lg_hit  = 1'b0;
    w_lg_port = 3'd0;
    w_lg_acc  = 3'd0;
    w_lg_addr = '0;
    for (int p = NUM_PORTS - 1; p >= 0; p--) begin
      if (w_tacc[p]) begin
        w_lg_hit  = 1'b1;
        w_lg_port = 3'(p);
        w_lg_acc  = req_acc[p*3 +: 3];
        w_lg_addr = req_addr[p*AW +: AW];
      end
    end
  end

  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      r_log_vld  <= 1'b0;
      r_log_port <= 3'd0;
      r_log_acc  <= 3'd0;
      r_log_addr <= '0;
    end else if (w_wr && w_is_log) begin
      r_log_vld  <= 1'b0;
    end else if (!r_log_vld && w_lg_hit) begin
      r_log_vld  <= 1'b1;
      r_log_port <= w_lg_port;
      r_log_acc  <= w_lg_acc;
      r_log_addr <= w_lg_addr;
    end
  end
`endif

  always_comb begin
    csr_rdata = '0;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      if (w_is_cfg && w_cfg_m == 3'(i / 8)) csr_rdata[(i % 8) * 8 +: 8] = r_cfg[i];
      if (w_is_paddr && w_pidx == 6'(i)) csr_rdata = {{(66 - AW){1'b0}}, r_addr[i]};
    end
`ifdef CORE_PMP_FAULT_LOG_EN
    if (w_is_log) csr_rdata = {r_log_vld, r_log_port, r_log_acc, {(57 - AW){1'b0}}, r_log_addr};
`endif
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    core_pmp_port #(.AW(AW), .NR(NUM_REGIONS), .NRA(NRA)) u_port (
      .g_clk       (g_clk),
      .g_reset     (g_reset),
      .i_cfg       (r_cfg),
      .i_addr      (r_addr),
      .i_req_valid (req_valid[p]),
      .o_req_ready (req_ready[p]),
      .i_req_addr  (req_addr[p*AW +: AW]),
      .i_req_prv   (req_prv[p*2 +: 2]),
      .i_req_acc   (req_acc[p*3 +: 3]),
      .o_rsp_valid (rsp_valid[p]),
      .i_rsp_ready (rsp_ready[p]),
      .o_rsp_trap  (rsp_trap[p]),
      .o_trap_acc  (w_tacc[p])
    );
  end
endmodule

// File: tb/tb_core_pmp_checker.sv
// Directed bench for core_pmp_checker (default parameters). Inputs change 1ns
// after the rising edge; registered outputs are sampled there too, and
// combinational CSR reads 1ns after their address is applied.
module tb_core_pmp_checker;
  localparam int AW = 56;
  localparam int NP = 2;
  localparam logic [1:0] PM = 2'b11, PU = 2'b00;
  localparam logic [2:0] AR = 3'b001, AWR = 3'b010, AX = 3'b100;

  logic g_clk = 1'b0, g_reset;
  logic csr_en, csr_wr, csr_error;
  logic [11:0] csr_addr;
  logic [63:0] csr_wdata, csr_rdata;
  logic [NP-1:0] req_valid, req_ready, rsp_valid, rsp_ready, rsp_trap;
  logic [NP*AW-1:0] req_addr;
  logic [NP*2-1:0] req_prv;
  logic [NP*3-1:0] req_acc;
  int n_tests = 0, n_fail = 0;
  logic [63:0] rd;
  logic er;

  core_pmp_checker dut (
    .g_clk(g_clk), .g_reset(g_reset), .csr_en(csr_en), .csr_wr(csr_wr),
    .csr_addr(csr_addr), .csr_wdata(csr_wdata), .csr_rdata(csr_rdata),
    .csr_error(csr_error), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_prv(req_prv), .req_acc(req_acc),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_trap(rsp_trap));

  always #5 g_clk = ~g_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic do_reset;
    g_reset = 1'b1; csr_en = 1'b0; csr_wr = 1'b0; csr_addr = '0; csr_wdata = '0;
    req_valid = '0; req_addr = '0; req_prv = '0; req_acc = '0; rsp_ready = '1;
    @(posedge g_clk); #1;
    g_reset = 1'b0;
  endtask

  task automatic csr_w(input logic [11:0] a, input logic [63:0] d);
    csr_en = 1'b1; csr_wr = 1'b1; csr_addr = a; csr_wdata = d;
    @(posedge g_clk); #1;
    csr_en = 1'b0; csr_wr = 1'b0;
  endtask

  task automatic csr_r(input logic [11:0] a, output logic [63:0] d, output logic e);
    csr_en = 1'b1; csr_wr = 1'b0; csr_addr = a;
    #1;
    d = csr_rdata; e = csr_error;
    csr_en = 1'b0;
  endtask

  task automatic set_req(input int p, input logic [AW-1:0] a, input logic [1:0] pv,
                         input logic [2:0] ac);
    req_valid[p] = 1'b1;
    req_addr[p*AW +: AW] = a;
    req_prv[p*2 +: 2] = pv;
    req_acc[p*3 +: 3] = ac;
  endtask

  task automatic req1(input int p, input logic [AW-1:0] a, input logic [1:0] pv,
                      input logic [2:0] ac);
    set_req(p, a, pv, ac);
    @(posedge g_clk); #1;
    req_valid[p] = 1'b0;
  endtask

  task automatic test_reset;
    do_reset();
    n_tests++;
    if ({rsp_valid, rsp_trap, req_ready} !== 6'b00_00_11) begin
      n_fail++; $display("FAIL reset_outputs: vld=%b trap=%b rdy=%b want 00 00 11", rsp_valid, rsp_trap, req_ready);
    end
    csr_r(12'h3A0, rd, er);
    n_tests++;
    if ({er, rd} !== 65'd0) begin n_fail++; $display("FAIL reset_cfg0: err=%b rd=%h want 0 0", er, rd); end
    csr_r(12'h3B5, rd, er);
    n_tests++;
    if ({er, rd} !== 65'd0) begin n_fail++; $display("FAIL reset_addr5: err=%b rd=%h want 0 0", er, rd); end
  endtask

  task automatic test_no_match;
    do_reset();
    req1(0, 56'h1000, PU, AR);
    n_tests++;
    if ({rsp_valid[0], rsp_trap[0]} !== 2'b11) begin n_fail++; $display("FAIL nomatch_u: v/t=%b%b want 11", rsp_valid[0], rsp_trap[0]); end
    req1(0, 56'h1000, PM, AR);
    n_tests++;
    if ({rsp_valid[0], rsp_trap[0]} !== 2'b10) begin n_fail++; $display("FAIL nomatch_m: v/t=%b%b want 10", rsp_valid[0], rsp_trap[0]); end
    req1(1, 56'h1000, PU, AX);
    n_tests++;
    if ({rsp_valid[1], rsp_trap[1]} !== 2'b11) begin n_fail++; $display("FAIL nomatch_p1: v/t=%b%b want 11", rsp_valid[1], rsp_trap[1]); end
    @(posedge g_clk); #1;
    n_tests++;
    if (rsp_valid !== 2'b00) begin n_fail++; $display("FAIL rsp_drain: vld=%b want 00", rsp_valid); end
  endtask

  task automatic test_csr_map;
    do_reset();
    csr_w(12'h3A0, 64'h7E);
    csr_r(12'h3A0, rd, er);
    n_tests++;
    if ({er, rd} !== {1'b0, 64'h1C}) begin n_fail++; $display("FAIL cfg_warl: err=%b rd=%h want 0 1c", er, rd); end
    csr_w(12'h3A2, 64'h0300);
    csr_r(12'h3A2, rd, er);
    n_tests++;
    if ({er, rd} !== {1'b0, 64'h0300}) begin n_fail++; $display("FAIL cfg2_rw: err=%b rd=%h want 0 300", er, rd); end
    csr_w(12'h3B3, '1);
    csr_r(12'h3B3, rd, er);
    n_tests++;
    if ({er, rd} !== {1'b0, 64'h003F_FFFF_FFFF_FFFF}) begin n_fail++; $display("FAIL addr_width: err=%b rd=%h want 0 3fffffffffffff", er, rd); end
    csr_r(12'h3A1, rd, er);
    n_tests++;
    if ({er, rd} !== {1'b1, 64'h0}) begin n_fail++; $display("FAIL odd_cfg: err=%b rd=%h want 1 0", er, rd); end
    csr_r(12'h3A4, rd, er);
    n_tests++;
    if ({er, rd} !== {1'b0, 64'h0}) begin n_fail++; $display("FAIL cfg4_unimpl: err=%b rd=%h want 0 0", er, rd); end
    csr_w(12'h3C0, 64'h55);
    csr_r(12'h3C0, rd, er);
    n_tests++;
    if ({er, rd} !== {1'b0, 64'h0}) begin n_fail++; $display("FAIL addr16_unimpl: err=%b rd=%h want 0 0", er, rd); end
    csr_r(12'h100, rd, er);
    n_tests++;
    if ({er, rd} !== {1'b1, 64'h0}) begin n_fail++; $display("FAIL out_of_range: err=%b rd=%h want 1 0", er, rd); end
  endtask

  task automatic test_napot;
    do_reset();
    csr_w(12'h3B0, 64'h3FF);
    csr_w(12'h3A0, 64'h1F);
    req1(0, 56'h1FFC, PU, AR);
    n_tests++;
    if ({rsp_valid[0], rsp_trap[0]} !== 2'b10) begin n_fail++; $display("FAIL napot_in: v/t=%b%b want 10", rsp_valid[0], rsp_trap[0]); end
    req1(0, 56'h2000, PU, AR);
    n_tests++;
    if ({rsp_valid[0], rsp_trap[0]} !== 2'b11) begin n_fail++; $display("FAIL napot_out: v/t=%b%b want 11", rsp_valid[0], rsp_trap[0]); end
  endtask

  task automatic test_tor_lock;
    do_reset();
    csr_w(12'h3B0, 64'h400);
    csr_w(12'h3B1, 64'h800);
    csr_w(12'h3A0, 64'h8900);
    csr_w(12'h3B0, 64'h0);
    csr_r(12'h3B0, rd, er);
    n_tests++;
    if (rd !== 64'h400) begin n_fail++; $display("FAIL tor_base_lock: rd=%h want 400", rd); end
    csr_w(12'h3B1, 64'h900);
    csr_r(12'h3B1, rd, er);
    n_tests++;
    if (rd !== 64'h800) begin n_fail++; $display("FAIL tor_top_lock: rd=%h want 800", rd); end
    req1(0, 56'h1000, PM, AWR);
    n_tests++;
    if (rsp_trap[0] !== 1'b1) begin n_fail++; $display("FAIL tor_m_write: trap=%b want 1", rsp_trap[0]); end
    req1(0, 56'h1000, PM, AR);
    n_tests++;
    if (rsp_trap[0] !== 1'b0) begin n_fail++; $display("FAIL tor_m_read: trap=%b want 0", rsp_trap[0]); end
    csr_w(12'h3A0, 64'h0003);
    csr_r(12'h3A0, rd, er);
    n_tests++;
    if (rd !== 64'h8903) begin n_fail++; $display("FAIL cfg_byte_lock: rd=%h want 8903", rd); end
    req1(0, 56'h1FFC, PU, AR);
    n_tests++;
    if (rsp_trap[0] !== 1'b0) begin n_fail++; $display("FAIL tor_u_in: trap=%b want 0", rsp_trap[0]); end
    req1(0, 56'h2000, PU, AR);
    n_tests++;
    if (rsp_trap[0] !== 1'b1) begin n_fail++; $display("FAIL tor_top_excl: trap=%b want 1", rsp_trap[0]); end
    req1(0, 56'h0FFC, PU, AR);
    n_tests++;
    if (rsp_trap[0] !== 1'b1) begin n_fail++; $display("FAIL tor_below_base: trap=%b want 1", rsp_trap[0]); end
  endtask

  task automatic test_priority;
    do_reset();
    csr_w(12'h3B0, 64'h400);
    csr_w(12'h3B1, 64'h003F_FFFF_FFFF_FFFF);
    csr_w(12'h3A0, 64'h1F11);
    req1(0, 56'h1000, PU, AWR);
    n_tests++;
    if (rsp_trap[0] !== 1'b1) begin n_fail++; $display("FAIL prio_w: trap=%b want 1", rsp_trap[0]); end
    req1(0, 56'h1000, PU, AR);
    n_tests++;
    if (rsp_trap[0] !== 1'b0) begin n_fail++; $display("FAIL prio_r: trap=%b want 0", rsp_trap[0]); end
    req1(1, 56'h1000, PU, AX);
    n_tests++;
    if (rsp_trap[1] !== 1'b1) begin n_fail++; $display("FAIL prio_x: trap=%b want 1", rsp_trap[1]); end
    req1(1, 56'h1004, PU, AWR);
    n_tests++;
    if (rsp_trap[1] !== 1'b0) begin n_fail++; $display("FAIL all_match: trap=%b want 0", rsp_trap[1]); end
  endtask

  task automatic test_back_to_back;
    do_reset();
    rsp_ready = 2'b01;
    set_req(1, 56'h1000, PU, AR);
    for (int c = 0; c < 4; c++) begin
      set_req(0, 56'h1000, (c % 2 == 1) ? PM : PU, AR);
      @(posedge g_clk); #1;
      set_req(1, 56'h1000, PM, AR);
      n_tests++;
      if ({rsp_valid[0], rsp_trap[0], req_ready[0]} !== {1'b1, (c % 2 == 0), 1'b1}) begin
        n_fail++; $display("FAIL stream_p0_c%0d: v/t/rdy=%b%b%b want 1%b1", c, rsp_valid[0], rsp_trap[0], req_ready[0], (c % 2 == 0));
      end
      n_tests++;
      if ({rsp_valid[1], rsp_trap[1], req_ready[1]} !== 3'b110) begin
        n_fail++; $display("FAIL hold_p1_c%0d: v/t/rdy=%b%b%b want 110", c, rsp_valid[1], rsp_trap[1], req_ready[1]);
      end
    end
    req_valid[0] = 1'b0;
    rsp_ready = 2'b11;
    #1;
    n_tests++;
    if (req_ready[1] !== 1'b1) begin n_fail++; $display("FAIL ready_release: rdy=%b want 1", req_ready[1]); end
    @(posedge g_clk); #1;
    req_valid[1] = 1'b0;
    n_tests++;
    if ({rsp_valid[1], rsp_trap[1]} !== 2'b10) begin n_fail++; $display("FAIL p1_next: v/t=%b%b want 10", rsp_valid[1], rsp_trap[1]); end
    @(posedge g_clk); #1;
    n_tests++;
    if (rsp_valid !== 2'b00) begin n_fail++; $display("FAIL b2b_drain: vld=%b want 00", rsp_valid); end
  endtask

  task automatic test_same_cycle;
    do_reset();
    csr_w(12'h3B0, 64'h3FF);
    csr_en = 1'b1; csr_wr = 1'b1; csr_addr = 12'h3A0; csr_wdata = 64'h1F;
    set_req(0, 56'h0, PU, AR);
    @(posedge g_clk); #1;
    csr_en = 1'b0; csr_wr = 1'b0; req_valid[0] = 1'b0;
    n_tests++;
    if (rsp_trap[0] !== 1'b1) begin n_fail++; $display("FAIL same_cycle_old: trap=%b want 1", rsp_trap[0]); end
    req1(0, 56'h0, PU, AR);
    n_tests++;
    if (rsp_trap[0] !== 1'b0) begin n_fail++; $display("FAIL same_cycle_new: trap=%b want 0", rsp_trap[0]); end
  endtask

  task automatic test_reset_mid;
    do_reset();
    rsp_ready = 2'b00;
    req1(0, 56'h1000, PU, AR);
    n_tests++;
    if ({rsp_valid[0], rsp_trap[0]} !== 2'b11) begin n_fail++; $display("FAIL mid_pre: v/t=%b%b want 11", rsp_valid[0], rsp_trap[0]); end
    #2 g_reset = 1'b1;
    #1;
    n_tests++;
    if ({rsp_valid, rsp_trap} !== 4'b0000) begin n_fail++; $display("FAIL mid_reset: vld=%b trap=%b want 00 00", rsp_valid, rsp_trap); end
    @(posedge g_clk); #1;
    g_reset = 1'b0; rsp_ready = 2'b11;
  endtask

  task automatic test_fault_log;
    do_reset();
`ifdef CORE_PMP_FAULT_LOG_EN
    req1(1, 56'h2000, PU, AR);
    req1(0, 56'h3000, PU, AWR);
    csr_r(12'h7C0, rd, er);
    n_tests++;
    if ({er, rd} !== {1'b0, 64'h9200_0000_0000_2000}) begin n_fail++; $display("FAIL log_first: err=%b rd=%h want 0 9200000000002000", er, rd); end
    csr_w(12'h7C0, 64'h0);
    csr_r(12'h7C0, rd, er);
    n_tests++;
    if (rd[63] !== 1'b0) begin n_fail++; $display("FAIL log_clear: valid=%b want 0", rd[63]); end
    set_req(0, 56'h4000, PU, AWR);
    set_req(1, 56'h5000, PU, AR);
    @(posedge g_clk); #1;
    req_valid = '0;
    csr_r(12'h7C0, rd, er);
    n_tests++;
    if (rd !== 64'h8400_0000_0000_4000) begin n_fail++; $display("FAIL log_simul: rd=%h want 8400000000004000", rd); end
`else
    req1(1, 56'h2000, PU, AR);
    csr_r(12'h7C0, rd, er);
    n_tests++;
    if ({er, rd} !== {1'b1, 64'h0}) begin n_fail++; $display("FAIL log_absent: err=%b rd=%h want 1 0", er, rd); end
`endif
  endtask

  initial begin
    test_reset();
    test_no_match();
    test_csr_map();
    test_napot();
    test_tor_lock();
    test_priority();
    test_back_to_back();
    test_same_cycle();
    test_reset_mid();
    test_fault_log();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
